// File: rtl/bet_round_controller.sv
// ---------------------------------------------------------------------------
// bet_round_controller
//
// Sequences one baccarat betting round around the card-dealing state machine:
// accepts and validates a wager, launches the deal, waits for the result,
// settles the wager against an 8-bit bankroll and detects bankruptcy.
//
// Ports:
//   slow_clock           clock, all logic on the rising edge
//   reset                synchronous active-high reset
//   place_bet            one-cycle wager request (honoured only in BET)
//   bet_amount[7:0]      unsigned wager
//   bet_choice[1:0]      01 player, 10 dealer, 11 tie, 00 invalid
//   round_done           dealing finished (honoured only in WAIT)
//   player_win           sampled with round_done
//   dealer_win           sampled with round_done
//   balance[7:0]         current bankroll (registered)
//   locked_bet[7:0]      wager captured for the current round (registered)
//   betenabled           high while accepting wagers
//   start_round          one-cycle pulse launching the deal
//   updatebalanceenable  one-cycle pulse during settlement
//   bet_error            one-cycle pulse after a rejected request
//   game_over            high once the bankroll has reached zero
// ---------------------------------------------------------------------------
module bet_round_controller #(
  parameter int INIT_BALANCE = 50,
  parameter int TIE_PAYOUT   = 8
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       place_bet,
  input  logic [7:0] bet_amount,
  input  logic [1:0] bet_choice,
  input  logic       round_done,
  input  logic       player_win,
  input  logic       dealer_win,
  output logic [7:0] balance,
  output logic [7:0] locked_bet,
  output logic       betenabled,
  output logic       start_round,
  output logic       updatebalanceenable,
  output logic       bet_error,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_BET,
    S_DEAL,
    S_WAIT,
    S_SETTLE,
    S_BROKE
  } state_t;

  localparam logic [7:0]  INIT_BAL = 8'(INIT_BALANCE);
  localparam logic [11:0] TIE_MULT = 12'(TIE_PAYOUT);

  state_t     state_reg, state_next;
  logic [7:0] balance_reg;
  logic [7:0] locked_bet_reg;
  logic [1:0] choice_reg;
  logic [1:0] result_reg;     // same encoding as bet_choice: 01/10/11
  logic       bet_error_reg;

  logic       bet_valid;
  logic [11:0] settle_wide;
  logic [7:0]  settle_balance;

  assign bet_valid = (bet_choice != 2'b00) && (bet_amount != 8'd0) &&
                     (bet_amount <= balance_reg);

  // Settlement computed at 12 bits: 255 + 15*255 still fits, so a single
  // saturation at the end is enough. Subtraction cannot underflow because the
  // wager never exceeds the balance at lock time.
  always_comb begin
    settle_wide = {4'd0, balance_reg};
    if (choice_reg == 2'b11) begin
      if (result_reg == 2'b11)
        settle_wide = {4'd0, balance_reg} + TIE_MULT * {4'd0, locked_bet_reg};
      else
        settle_wide = {4'd0, balance_reg} - {4'd0, locked_bet_reg};
    end else if (result_reg == 2'b11) begin
      settle_wide = {4'd0, balance_reg};  // push
    end else if (choice_reg == result_reg) begin
      settle_wide = {4'd0, balance_reg} + {4'd0, locked_bet_reg};
    end else begin
      settle_wide = {4'd0, balance_reg} - {4'd0, locked_bet_reg};
    end
    settle_balance = (settle_wide > 12'd255) ? 8'hFF : settle_wide[7:0];
  end

  // State register
  always_ff @(posedge slow_clock) begin
    if (reset) state_reg <= S_BET;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BET:    if (place_bet && bet_valid) state_next = S_DEAL;
      S_DEAL:   state_next = S_WAIT;
      S_WAIT:   if (round_done) state_next = S_SETTLE;
      S_SETTLE: state_next = (settle_balance == 8'd0) ? S_BROKE : S_BET;
      S_BROKE:  state_next = S_BROKE;
      default:  state_next = S_BET;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    betenabled          = (state_reg == S_BET);
    start_round         = (state_reg == S_DEAL);
    updatebalanceenable = (state_reg == S_SETTLE);
    game_over           = (state_reg == S_BROKE);
  end

  // Datapath registers
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      balance_reg    <= INIT_BAL;
      locked_bet_reg <= 8'd0;
      choice_reg     <= 2'b00;
      result_reg     <= 2'b11;
      bet_error_reg  <= 1'b0;
    end else begin
      bet_error_reg <= (state_reg == S_BET) && place_bet && !bet_valid;
      if (state_reg == S_BET && place_bet && bet_valid) begin
        locked_bet_reg <= bet_amount;
        choice_reg     <= bet_choice;
      end
      if (state_reg == S_WAIT && round_done) begin
        // Exactly one winner flag names that side; both or neither is a tie.
        if (player_win ^ dealer_win) result_reg <= {dealer_win, player_win};
        else                         result_reg <= 2'b11;
      end
      if (state_reg == S_SETTLE)
        balance_reg <= settle_balance;
    end
  end

  assign balance    = balance_reg;
  assign locked_bet = locked_bet_reg;
  assign bet_error  = bet_error_reg;

endmodule

// File: tb/tb_bet_round_controller.sv
module tb_bet_round_controller;

  localparam int INIT_BALANCE = 50;
  localparam int TIE_PAYOUT   = 8;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b0;
  logic       place_bet = 1'b0;
  logic [7:0] bet_amount = 8'd0;
  logic [1:0] bet_choice = 2'b00;
  logic       round_done = 1'b0;
  logic       player_win = 1'b0;
  logic       dealer_win = 1'b0;
  logic [7:0] balance;
  logic [7:0] locked_bet;
  logic       betenabled;
  logic       start_round;
  logic       updatebalanceenable;
  logic       bet_error;
  logic       game_over;

  bet_round_controller #(
    .INIT_BALANCE(INIT_BALANCE),
    .TIE_PAYOUT  (TIE_PAYOUT)
  ) dut (
    .slow_clock         (slow_clock),
    .reset              (reset),
    .place_bet          (place_bet),
    .bet_amount         (bet_amount),
    .bet_choice         (bet_choice),
    .round_done         (round_done),
    .player_win         (player_win),
    .dealer_win         (dealer_win),
    .balance            (balance),
    .locked_bet         (locked_bet),
    .betenabled         (betenabled),
    .start_round        (start_round),
    .updatebalanceenable(updatebalanceenable),
    .bet_error          (bet_error),
    .game_over          (game_over)
  );

  always #5 slow_clock = ~slow_clock;

  // Expected output events: 0 = error pulse, 1 = start pulse, 2 = settlement
  typedef struct {
    int kind;
    int locked;
    int bal;
    int gover;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state (phase names are the bench's own bookkeeping)
  localparam int P_BET = 0, P_DEAL = 1, P_WAIT = 2, P_BROKE = 3;
  int m_phase  = P_BET;
  int m_bal    = INIT_BALANCE;
  int m_locked = 0;
  int m_choice = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Payout rules stated directly: win pays even money, tie bet pays
  // TIE_PAYOUT-to-one, player/dealer bet on a tie is a push, else lose.
  function automatic int settle(input int bal, input int bet, input int choice,
                                input bit pw, input bit dw);
    int res, r;
    if (pw && !dw)      res = 1;
    else if (dw && !pw) res = 2;
    else                res = 3;
    if (choice == 3)     r = (res == 3) ? bal + TIE_PAYOUT * bet : bal - bet;
    else if (res == 3)   r = bal;
    else if (choice == res) r = bal + bet;
    else                 r = bal - bet;
    if (r > 255) r = 255;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit   settle_pending = 0;
  exp_t pend;

  task automatic pop_expect(input int kind, input string what, output exp_t e);
    if (exp_q.size() == 0) begin
      chk({"unexpected_", what}, 1, 0);
      e.kind = -1;
    end else begin
      e = exp_q.pop_front();
      chk({"event_kind_", what}, kind, e.kind);
    end
  endtask

  always @(negedge slow_clock) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      settle_pending = 0;
    end else begin
      if (settle_pending) begin
        settle_pending = 0;
        chk("settle_balance", int'(balance), pend.bal);
        chk("settle_game_over", int'(game_over), pend.gover);
        chk("settle_betenabled", int'(betenabled), pend.gover ? 0 : 1);
      end
      if (bet_error) begin
        pop_expect(0, "bet_error", e);
        if (e.kind == 0) begin
          chk("error_locked_bet", int'(locked_bet), e.locked);
          chk("error_balance", int'(balance), e.bal);
          chk("error_betenabled", int'(betenabled), 1);
        end
      end
      if (start_round) begin
        pop_expect(1, "start_round", e);
        if (e.kind == 1) begin
          chk("start_locked_bet", int'(locked_bet), e.locked);
          chk("start_betenabled", int'(betenabled), 0);
        end
      end
      if (updatebalanceenable) begin
        pop_expect(2, "updatebalanceenable", e);
        if (e.kind == 2) begin
          pend = e;
          settle_pending = 1;
        end
      end
    end
  end

  // ---------------- driver (runs at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge slow_clock); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge slow_clock); #1;
    reset = 1'b0;
    m_phase = P_BET; m_bal = INIT_BALANCE; m_locked = 0;
    $display("txn reset");
    chk("reset_balance", int'(balance), INIT_BALANCE);
    chk("reset_locked_bet", int'(locked_bet), 0);
    chk("reset_betenabled", int'(betenabled), 1);
    chk("reset_game_over", int'(game_over), 0);
    chk("reset_pulses", int'({start_round, updatebalanceenable, bet_error}), 0);
  endtask

  task automatic place(input int amt, input int ch);
    exp_t e;
    bit valid;
    place_bet = 1'b1; bet_amount = 8'(amt); bet_choice = 2'(ch);
    if (m_phase == P_BET) begin
      valid = (ch != 0) && (amt >= 1) && (amt <= m_bal);
      if (valid) begin
        m_locked = amt; m_choice = ch; m_phase = P_DEAL;
        e = '{kind: 1, locked: amt, bal: m_bal, gover: 0};
      end else begin
        e = '{kind: 0, locked: m_locked, bal: m_bal, gover: 0};
      end
      exp_q.push_back(e);
      $display("txn place amt=%0d choice=%0d accepted=%0d", amt, ch, valid);
    end else begin
      $display("txn place amt=%0d choice=%0d ignored", amt, ch);
    end
    @(posedge slow_clock); #1;
    place_bet = 1'b0;
    // Wager inputs wander after lock; they must not matter.
    bet_amount = 8'($urandom); bet_choice = 2'($urandom);
  endtask

  task automatic finish_round(input int delay, input bit pw, input bit dw);
    exp_t e;
    int nb;
    @(posedge slow_clock); #1;           // DEAL -> WAIT
    m_phase = P_WAIT;
    repeat (delay) begin
      place_bet = 1'($urandom);          // ignored outside BET
      bet_amount = 8'd1; bet_choice = 2'b01;
      @(posedge slow_clock); #1;
      place_bet = 1'b0;
    end
    round_done = 1'b1; player_win = pw; dealer_win = dw;
    nb = settle(m_bal, m_locked, m_choice, pw, dw);
    e = '{kind: 2, locked: m_locked, bal: nb, gover: (nb == 0)};
    exp_q.push_back(e);
    $display("txn round bet=%0d choice=%0d pw=%0d dw=%0d balance %0d->%0d",
             m_locked, m_choice, pw, dw, m_bal, nb);
    @(posedge slow_clock); #1;           // SETTLE
    round_done = 1'b0; player_win = 1'($urandom); dealer_win = 1'($urandom);
    @(posedge slow_clock); #1;           // BET or BROKE
    m_bal = nb;
    m_phase = (nb == 0) ? P_BROKE : P_BET;
  endtask

  task automatic poke_done();
    round_done = 1'b1; player_win = 1'($urandom); dealer_win = 1'($urandom);
    $display("txn stray round_done");
    @(posedge slow_clock); #1;
    round_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int amt, ch, r;
    @(posedge slow_clock); #1;
    do_reset();
    idle(5);
    chk("idle_balance", int'(balance), 50);

    // Simple player win
    place(10, 1);
    finish_round(0, 1, 0);
    chk("player_win_balance", int'(balance), 60);
    chk("player_win_betenabled", int'(betenabled), 1);

    // Back-to-back rejected requests
    do_reset();
    place(0, 1);
    place(51, 1);
    place(5, 0);
    idle(2);
    chk("rejects_betenabled", int'(betenabled), 1);

    // Tie payouts and saturation, then a push
    place(20, 3); finish_round(1, 1, 1);
    place(10, 3); finish_round(2, 0, 0);
    place(5, 1);  finish_round(0, 1, 1);
    chk("push_balance", int'(balance), 255);

    // Bankruptcy, ignored inputs, recovery by reset
    do_reset();
    place(50, 2); finish_round(0, 1, 0);
    place(5, 1);
    poke_done();
    idle(2);
    chk("broke_game_over", int'(game_over), 1);
    chk("broke_balance", int'(balance), 0);
    do_reset();

    // Reset during WAIT
    place(30, 1);
    @(posedge slow_clock); #1;
    do_reset();
    poke_done();
    idle(2);
    chk("post_reset_balance", int'(balance), 50);

    // Randomized rounds
    for (int i = 0; i < 80; i++) begin
      if (m_phase == P_BROKE) begin
        place(1, 1);
        poke_done();
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0)      amt = 0;
        else if (r == 1) amt = (m_bal == 255) ? 0 : m_bal + 1;
        else             amt = $urandom_range(1, m_bal);
        ch = $urandom_range(0, 3);
        place(amt, ch);
        if (m_phase == P_DEAL) begin
          if ($urandom_range(0, 15) == 0) begin
            @(posedge slow_clock); #1;
            do_reset();
          end else begin
            finish_round($urandom_range(0, 3), 1'($urandom), 1'($urandom));
          end
        end
      end
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
